// File: rtl/avalon_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel timer.
// Registered readdata is driven by the slave side.
interface avalon_multi_timer_if #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_multi_timer.sv
// Multi-channel interval timer: per-channel prescaled down-counters,
// one-shot/continuous modes, snapshots, and a shared masked irq.
module avalon_multi_timer #(
  parameter int          NUM_CH       = 4,
  parameter int          COUNT_W      = 48,
  parameter int          PRESC_W      = 16,
  parameter logic [63:0] RESET_PERIOD = 64'd99,
  localparam int         ADDR_W       = $clog2(NUM_CH) + 3
) (
  input  logic                clk,
  input  logic                reset,
  avalon_multi_timer_if.slave bus,
  output logic                irq
);

  localparam int CH_W = (ADDR_W > 3) ? ADDR_W - 3 : 1;

  logic [CH_W-1:0] ch;
  logic [2:0]      rsel;
  logic            ch_ok;
  logic            wr_en;

  if (ADDR_W > 3) begin : g_ch
    assign ch = bus.address[ADDR_W-1:3];
  end else begin : g_ch1
    assign ch = '0;
  end

  assign rsel  = bus.address[2:0];
  assign ch_ok = 32'(ch) < 32'(NUM_CH);
  assign wr_en = bus.chipselect & ~bus.write_n & ch_ok;

  logic [NUM_CH-1:0]  to_q, to_d;
  logic [NUM_CH-1:0]  run_q, run_d;
  logic [NUM_CH-1:0]  ito_q, ito_d;
  logic [NUM_CH-1:0]  cont_q, cont_d;
  logic [NUM_CH-1:0]  reload_q, reload_d;
  logic [PRESC_W-1:0] presc_q [NUM_CH];
  logic [PRESC_W-1:0] presc_d [NUM_CH];
  logic [PRESC_W-1:0] pc_q [NUM_CH];
  logic [PRESC_W-1:0] pc_d [NUM_CH];
  logic [COUNT_W-1:0] period_q [NUM_CH];
  logic [COUNT_W-1:0] period_d [NUM_CH];
  logic [COUNT_W-1:0] cnt_q [NUM_CH];
  logic [COUNT_W-1:0] cnt_d [NUM_CH];
  logic [COUNT_W-1:0] snap_q [NUM_CH];
  logic [COUNT_W-1:0] snap_d [NUM_CH];
  logic [31:0]        readdata_q, readdata_d;
  logic               irq_q, irq_d;

  logic [NUM_CH-1:0] sel, tick, evt, pend;
  logic [63:0]       per64 [NUM_CH];
  logic [63:0]       snap64 [NUM_CH];

  // Per-channel decode: selection, tick, timeout event, pending bit
  always_comb begin
    sel  = '0;
    tick = '0;
    evt  = '0;
    pend = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      per64[i]  = 64'(period_q[i]);
      snap64[i] = 64'(snap_q[i]);
      sel[i]    = wr_en && (ch == CH_W'(i));
      tick[i]   = run_q[i] && !reload_q[i] &&
                  (pc_q[i] == presc_q[i]);
      evt[i]    = tick[i] && (cnt_q[i] == '0);
      pend[i]   = to_q[i] & ito_q[i];
    end
  end

  // Channel state update: count, register writes, timeout, reload
  always_comb begin
    to_d     = to_q;
    run_d    = run_q;
    ito_d    = ito_q;
    cont_d   = cont_q;
    reload_d = '0;
    presc_d  = presc_q;
    pc_d     = pc_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!run_q[i] || tick[i]) begin
        pc_d[i] = '0;
      end else begin
        pc_d[i] = pc_q[i] + PRESC_W'(1);
      end
      if (tick[i]) begin
        if (evt[i]) begin
          cnt_d[i] = period_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] - COUNT_W'(1);
        end
      end
      if (sel[i]) begin
        case (rsel)
          3'd0: begin
            if (bus.writedata[0]) to_d[i] = 1'b0;
          end
          3'd1: begin
            ito_d[i]  = bus.writedata[0];
            cont_d[i] = bus.writedata[1];
            if (bus.writedata[3]) begin
              run_d[i] = 1'b0;
            end else if (bus.writedata[2]) begin
              run_d[i] = 1'b1;
            end
          end
          3'd2: begin
            period_d[i] = COUNT_W'({per64[i][63:32],
                                    bus.writedata});
            reload_d[i] = 1'b1;
          end
          3'd3: begin
            if (COUNT_W > 32) begin
              period_d[i] = COUNT_W'({bus.writedata,
                                      per64[i][31:0]});
              reload_d[i] = 1'b1;
            end
          end
          3'd4, 3'd5: snap_d[i] = cnt_q[i];
          3'd6: presc_d[i] = PRESC_W'(bus.writedata);
          default: ;
        endcase
      end
      // a timeout beats a same-cycle W1C
      if (evt[i]) begin
        to_d[i] = 1'b1;
        if (!cont_q[i]) run_d[i] = 1'b0;
      end
      // reload after a period write overrides everything else
      if (reload_q[i]) begin
        cnt_d[i] = period_q[i];
        run_d[i] = 1'b0;
        pc_d[i]  = '0;
      end
    end
  end

  // Read mux and interrupt combine
  always_comb begin
    readdata_d = '0;
    irq_d      = |pend;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_ok && (ch == CH_W'(i))) begin
        case (rsel)
          3'd0: readdata_d = {30'd0, run_q[i], to_q[i]};
          3'd1: readdata_d = {30'd0, cont_q[i], ito_q[i]};
          3'd2: readdata_d = per64[i][31:0];
          3'd3: readdata_d = per64[i][63:32];
          3'd4: readdata_d = snap64[i][31:0];
          3'd5: readdata_d = snap64[i][63:32];
          3'd6: readdata_d = 32'(presc_q[i]);
          default: readdata_d = 32'(pend);
        endcase
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      to_q       <= '0;
      run_q      <= '0;
      ito_q      <= '0;
      cont_q     <= '0;
      reload_q   <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        presc_q[i]  <= '0;
        pc_q[i]     <= '0;
        period_q[i] <= COUNT_W'(RESET_PERIOD);
        cnt_q[i]    <= COUNT_W'(RESET_PERIOD);
        snap_q[i]   <= '0;
      end
    end else begin
      to_q       <= to_d;
      run_q      <= run_d;
      ito_q      <= ito_d;
      cont_q     <= cont_d;
      reload_q   <= reload_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      presc_q    <= presc_d;
      pc_q       <= pc_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Self-checking bench for avalon_multi_timer.
// Timeout times come from (N+1)*(P+1); registers from a shadow map.
`timescale 1ns/1ps
module tb_avalon_multi_timer;
  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq;
  int          vectors = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  avalon_multi_timer_if #(.ADDR_W(AW)) bus ();

  avalon_multi_timer #(
    .NUM_CH(4),
    .COUNT_W(48),
    .PRESC_W(16),
    .RESET_PERIOD(64'd99)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wr(input int c, input int r, input logic [31:0] d);
    @(negedge clk);
    bus.address    = AW'(c * 8 + r);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input int c, input int r, output logic [31:0] d);
    @(negedge clk);
    bus.address    = AW'(c * 8 + r);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(posedge clk);
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int c, input int budget,
                         output int unsigned seen,
                         output logic [31:0] st, output bit ok);
    ok = 1'b0;
    seen = 0;
    st = '0;
    for (int k = 0; k < budget; k++) begin
      rd(c, 0, st);
      if (st[0]) begin
        seen = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic quiesce;
    for (int c = 0; c < 4; c++) begin
      wr(c, 1, 32'h8);
      wr(c, 0, 32'h1);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if (bus.readdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: rd=%0h irq=%b expected 0/0",
               bus.readdata, irq);
    end
    rd(0, 2, d);
    vectors++;
    if (d !== 32'd99) begin
      errors++;
      $display("FAIL reset_period: got %0d expected 99", d);
    end
    rd(0, 0, d);
    vectors++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reset_status: got %0h expected 0", d);
    end
    rd(0, 7, d);
    vectors++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reset_pending: got %0h expected 0", d);
    end
  endtask

  task automatic test_continuous;
    logic [31:0] st, d;
    int unsigned c0, s1, s2;
    bit ok;
    wr(1, 2, 9);
    wr(1, 6, 0);
    wr(1, 1, 32'h7);
    c0 = cyc;
    wait_to(1, 40, s1, st, ok);
    vectors++;
    if (!ok || s1 - c0 != 11 || st[1] !== 1'b1) begin
      errors++;
      $display("FAIL cont_first: ok=%0d dt=%0d run=%b expected dt=11 run=1",
               ok, s1 - c0, st[1]);
    end
    vectors++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL cont_irq: got %b expected 1", irq);
    end
    wr(1, 0, 32'h1);
    rd(1, 7, d);
    vectors++;
    if (irq !== 1'b0 || d !== 32'd0) begin
      errors++;
      $display("FAIL cont_w1c: irq=%b pend=%0h expected 0/0", irq, d);
    end
    wait_to(1, 40, s2, st, ok);
    vectors++;
    if (!ok || s2 - s1 != 10 || st[1] !== 1'b1) begin
      errors++;
      $display("FAIL cont_second: ok=%0d dt=%0d run=%b expected dt=10 run=1",
               ok, s2 - s1, st[1]);
    end
    wr(1, 1, 32'h8);
    wr(1, 0, 32'h1);
  endtask

  task automatic test_oneshot;
    logic [31:0] st, d;
    int unsigned c0, s1;
    bit ok;
    wr(2, 2, 3);
    wr(2, 6, 4);
    wr(2, 1, 32'h5);
    c0 = cyc;
    wait_to(2, 60, s1, st, ok);
    vectors++;
    if (!ok || s1 - c0 != 21 || st[1] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_to: ok=%0d dt=%0d run=%b expected dt=21 run=0",
               ok, s1 - c0, st[1]);
    end
    vectors++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_irq: got %b expected 1", irq);
    end
    idle(7);
    wr(2, 4, 0);
    rd(2, 4, d);
    vectors++;
    if (d !== 32'd3) begin
      errors++;
      $display("FAIL oneshot_snap: got %0h expected 3", d);
    end
    rd(2, 0, d);
    vectors++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL oneshot_hold: status %0h expected 1", d);
    end
    wr(2, 1, 32'h0);
    wr(2, 0, 32'h1);
  endtask

  task automatic test_wide;
    logic [31:0] d, hi, lo;
    logic [63:0] e;
    int unsigned c0, cs;
    wr(3, 3, 1);
    wr(3, 2, 0);
    idle(1);
    wr(3, 4, 0);
    rd(3, 5, hi);
    rd(3, 4, lo);
    vectors++;
    if (hi !== 32'd1 || lo !== 32'd0) begin
      errors++;
      $display("FAIL wide_snap: got %0h_%0h expected 1_0", hi, lo);
    end
    rd(3, 3, d);
    vectors++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL wide_ph: got %0h expected 1", d);
    end
    wr(3, 6, 0);
    wr(3, 1, 32'h4);
    c0 = cyc;
    idle(5);
    wr(3, 4, 0);
    cs = cyc;
    e = 64'h1_0000_0000 - 64'(cs - 1 - c0);
    rd(3, 5, hi);
    rd(3, 4, lo);
    vectors++;
    if ({hi, lo} !== e) begin
      errors++;
      $display("FAIL wide_run_snap: got %0h_%0h expected %0h",
               hi, lo, e);
    end
    wr(3, 2, 5);
    idle(1);
    rd(3, 0, d);
    vectors++;
    if (d[1] !== 1'b0) begin
      errors++;
      $display("FAIL wide_stop: run %b expected 0", d[1]);
    end
    wr(3, 4, 0);
    rd(3, 5, hi);
    rd(3, 4, lo);
    vectors++;
    if (hi !== 32'd1 || lo !== 32'd5) begin
      errors++;
      $display("FAIL wide_reload: got %0h_%0h expected 1_5", hi, lo);
    end
  endtask

  task automatic test_collision;
    logic [31:0] d;
    int unsigned c0;
    wr(0, 2, 4);
    wr(0, 6, 0);
    wr(0, 1, 32'h6);
    c0 = cyc;
    idle(4);
    wr(0, 0, 32'h1);
    rd(0, 0, d);
    vectors++;
    if (cyc - c0 != 6 || d !== 32'd3) begin
      errors++;
      $display("FAIL collide_set: status %0h at +%0d expected 3 at +6",
               d, cyc - c0);
    end
    wr(0, 1, 32'hC);
    rd(0, 0, d);
    vectors++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL stop_prio: status %0h expected 1", d);
    end
    rd(0, 1, d);
    vectors++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL ctrl_read: got %0h expected 0", d);
    end
    wr(0, 0, 32'h1);
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    bit ok;
    wr(3, 3, 0);
    wr(3, 2, 5);
    wr(0, 2, 6);
    wr(0, 6, 0);
    wr(3, 6, 0);
    wr(0, 1, 32'h5);
    wr(3, 1, 32'h5);
    ok = 1'b0;
    d = '0;
    for (int k = 0; k < 30; k++) begin
      rd(0, 7, d);
      if (d != 0) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok || d !== 32'h9 || irq !== 1'b1) begin
      errors++;
      $display("FAIL simul_pend: got %0h irq=%b expected 9/1", d, irq);
    end
    wr(0, 0, 32'h1);
    rd(2, 7, d);
    vectors++;
    if (d !== 32'h8 || irq !== 1'b1) begin
      errors++;
      $display("FAIL simul_clr0: got %0h irq=%b expected 8/1", d, irq);
    end
    quiesce();
  endtask

  task automatic test_random_timers;
    logic [31:0] st, d;
    int unsigned c0, s1, n, p, cont, c;
    bit ok;
    for (int it = 0; it < 8; it++) begin
      c = $urandom_range(0, 3);
      n = $urandom_range(0, 12);
      p = $urandom_range(0, 3);
      cont = $urandom_range(0, 1);
      wr(c, 3, 0);
      wr(c, 2, n);
      wr(c, 6, p);
      wr(c, 1, 32'h5 | (cont << 1));
      c0 = cyc;
      wait_to(c, 300, s1, st, ok);
      vectors++;
      if (!ok || s1 - c0 != (n + 1) * (p + 1) + 1 ||
          st[1] !== cont[0]) begin
        errors++;
        $display("FAIL rnd_to ch%0d n=%0d p=%0d: dt=%0d run=%b expected %0d/%0d",
                 c, n, p, s1 - c0, st[1], (n + 1) * (p + 1) + 1, cont);
      end
      rd(c, 7, d);
      vectors++;
      if (d !== (32'd1 << c) || irq !== 1'b1) begin
        errors++;
        $display("FAIL rnd_pend ch%0d: got %0h irq=%b expected %0h/1",
                 c, d, irq, 32'd1 << c);
      end
      if (cont == 0) begin
        wr(c, 4, 0);
        rd(c, 4, d);
        vectors++;
        if (d !== n) begin
          errors++;
          $display("FAIL rnd_snap ch%0d: got %0d expected %0d", c, d, n);
        end
      end
      wr(c, 1, 32'h8);
      wr(c, 0, 32'h1);
    end
  endtask

  task automatic test_regs_random;
    logic [63:0] per [4];
    logic [15:0] psc [4];
    logic [1:0]  ctl [4];
    logic [31:0] d, e;
    int c, r;
    int regs [5] = '{1, 2, 3, 6, 7};
    for (int i = 0; i < 4; i++) begin
      per[i] = 64'd0;
      psc[i] = 16'd0;
      ctl[i] = 2'd0;
      wr(i, 3, 0);
      wr(i, 2, 0);
      wr(i, 6, 0);
      wr(i, 1, 32'h8);
    end
    for (int k = 0; k < 48; k++) begin
      c = $urandom_range(0, 3);
      r = regs[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        if (r == 1) d = d & 32'hFFFF_FFFB;
        wr(c, r, d);
        case (r)
          1: ctl[c] = d[1:0];
          2: per[c] = {per[c][63:32], d};
          3: per[c] = {d, per[c][31:0]} & 64'hFFFF_FFFF_FFFF;
          6: psc[c] = d[15:0];
          default: ;
        endcase
      end else begin
        rd(c, r, d);
        case (r)
          1: e = {30'd0, ctl[c]};
          2: e = per[c][31:0];
          3: e = per[c][63:32];
          6: e = {16'd0, psc[c]};
          default: e = 32'd0;
        endcase
        vectors++;
        if (d !== e) begin
          errors++;
          $display("FAIL reg_rt ch%0d r%0d: got %0h expected %0h",
                   c, r, d, e);
        end
      end
    end
    vectors++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reg_irq: got %b expected 0", irq);
    end
    quiesce();
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    wr(1, 2, 20);
    wr(1, 6, 2);
    wr(1, 1, 32'h7);
    idle(3);
    wr(1, 4, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if (irq !== 1'b0 || bus.readdata !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_out: irq=%b rd=%0h expected 0/0",
               irq, bus.readdata);
    end
    rd(1, 0, d);
    vectors++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_status: got %0h expected 0", d);
    end
    rd(1, 2, d);
    vectors++;
    if (d !== 32'd99) begin
      errors++;
      $display("FAIL mid_reset_period: got %0d expected 99", d);
    end
    rd(1, 4, d);
    vectors++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_snap: got %0h expected 0", d);
    end
    rd(1, 6, d);
    vectors++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_presc: got %0h expected 0", d);
    end
    rd(1, 1, d);
    vectors++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got %0h expected 0", d);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    test_reset();
    test_continuous();
    test_oneshot();
    test_wide();
    test_collision();
    test_simultaneous();
    test_random_timers();
    test_regs_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
